// File: rtl/dmem_responder.sv
// Data-side memory responder for the 5-stage RV32 core.
// Word-organised RAM with byte/half lanes and sign/zero extension,
// sticky misaligned-access trap, and a 16-byte MMIO window holding a
// console TX FIFO, a free-running cycle counter, a status register and
// an error-clear register.
//
// Console drain handshake: a byte moves from the FIFO to the sink on a
// rising clk edge exactly when cons_valid && cons_ready; cons_valid never
// drops and cons_data never changes while cons_valid is high and
// cons_ready is low.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          CONS_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] read_data,
  output logic        misalign_err,
  output logic [31:0] err_addr,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(CONS_DEPTH);
  localparam int CW = PW + 1;

  // MMIO register offsets (addr[3:2])
  localparam logic [1:0] REG_CONS   = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [CONS_DEPTH];

  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_word_q,  rd_word_d;
  logic [1:0]    rd_off_q,   rd_off_d;
  logic [1:0]    rd_size_q,  rd_size_d;
  logic          rd_uns_q,   rd_uns_d;

  logic          err_q,      err_d;
  logic [31:0]   eaddr_q,    eaddr_d;
  logic [31:0]   cyc_q,      cyc_d;
  logic [7:0]    ovf_q,      ovf_d;

  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] cnt_q,      cnt_d;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic          req;
  logic          is_mmio;
  logic          size_half;
  logic          size_word;
  logic          misalign;
  logic [AW-1:0] ram_idx;
  logic [1:0]    mmio_reg;
  logic          mmio_word;
  logic          st_ram;
  logic          ld_ok;
  logic          push;
  logic          clr;

  // Classify the current request: region, alignment and side effects
  always_comb begin
    req       = mem_read | mem_write;
    is_mmio   = (addr[31:4] == MMIO_BASE[31:4]);
    size_half = (mem_size == 2'b01);
    size_word = mem_size[1];
    misalign  = req && ((size_half && addr[0]) ||
                        (size_word && (addr[1:0] != 2'b00)));
    ram_idx   = addr[AW+1:2];
    mmio_reg  = addr[3:2];
    // Only aligned word accesses have any effect inside the MMIO window
    mmio_word = is_mmio && size_word && !misalign;
    // A combined read+write is a store; misaligned accesses do nothing
    st_ram    = mem_write && !is_mmio && !misalign;
    ld_ok     = mem_read && !mem_write && !misalign;
    push      = mem_write && mmio_word && (mmio_reg == REG_CONS);
    clr       = mem_write && mmio_word && (mmio_reg == REG_CLEAR);
  end

  // ---------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] wd_lanes;

  // Replicate store data across lanes and pick the lanes to update
  always_comb begin
    be       = 4'b0000;
    wd_lanes = write_data;
    case (mem_size)
      2'b00: begin
        be       = 4'b0001 << addr[1:0];
        wd_lanes = {4{write_data[7:0]}};
      end
      2'b01: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{write_data[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = write_data;
      end
    endcase
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (st_ram) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) ram_q[ram_idx][l*8 +: 8] <= wd_lanes[l*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Console FIFO control
  // ---------------------------------------------------------------------
  logic fifo_full;
  logic pop;
  logic push_acc;

  // Pop/push acceptance, pointer and occupancy update
  always_comb begin
    cons_valid = (cnt_q != '0);
    fifo_full  = (cnt_q == CW'(CONS_DEPTH));
    pop        = cons_valid && cons_ready;
    // A full FIFO still takes a push when the head leaves this cycle
    push_acc   = push && (!fifo_full || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_acc, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO payload storage; only the occupied slots are ever observed
  always_ff @(posedge clk) begin
    if (push_acc) fifo_q[wr_ptr_q] <= write_data[7:0];
  end

  // Head byte is forced to zero while the FIFO is empty
  always_comb begin
    cons_data = cons_valid ? fifo_q[rd_ptr_q] : 8'h00;
  end

  // ---------------------------------------------------------------------
  // Counters and error tracking
  // ---------------------------------------------------------------------
  // Cycle counter, overflow counter and sticky misalignment record
  always_comb begin
    cyc_d   = cyc_q + 32'd1;

    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 8'h00;
    end else if (push && !push_acc && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end

    err_d   = err_q;
    eaddr_d = eaddr_q;
    if (clr) begin
      err_d   = 1'b0;
      eaddr_d = 32'h0;
    end else if (misalign && !err_q) begin
      err_d   = 1'b1;
      eaddr_d = addr;
    end
  end

  // ---------------------------------------------------------------------
  // Load capture
  // ---------------------------------------------------------------------
  logic [2:0]  cnt3;
  logic [31:0] mmio_rdata;

  // MMIO read mux (only the counter and status registers read non-zero)
  always_comb begin
    cnt3 = 3'(cnt_q);
    case (mmio_reg)
      REG_CYCLE:  mmio_rdata = cyc_q;
      REG_STATUS: mmio_rdata = {16'h0, ovf_q, 5'b0, cnt3};
      default:    mmio_rdata = 32'h0;
    endcase
  end

  // Select what the load pipeline register captures this cycle
  always_comb begin
    rd_valid_d = 1'b0;
    rd_word_d  = 32'h0;
    rd_off_d   = 2'b00;
    rd_size_d  = 2'b10;
    rd_uns_d   = 1'b0;
    if (ld_ok) begin
      if (!is_mmio) begin
        rd_valid_d = 1'b1;
        rd_word_d  = ram_q[ram_idx];
        rd_off_d   = addr[1:0];
        rd_size_d  = mem_size;
        rd_uns_d   = mem_unsigned;
      end else if (mmio_word) begin
        rd_valid_d = 1'b1;
        rd_word_d  = mmio_rdata;
      end
    end
  end

  // Extract and extend the registered word for the writeback mux
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_word_q[rd_off_q*8 +: 8];
    h = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    read_data = 32'h0;
    if (rd_valid_q) begin
      case (rd_size_q)
        2'b00:   read_data = {{24{!rd_uns_q && b[7]}}, b};
        2'b01:   read_data = {{16{!rd_uns_q && h[15]}}, h};
        default: read_data = rd_word_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // All control state clears asynchronously; in-flight loads are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_word_q  <= 32'h0;
      rd_off_q   <= 2'b00;
      rd_size_q  <= 2'b10;
      rd_uns_q   <= 1'b0;
      err_q      <= 1'b0;
      eaddr_q    <= 32'h0;
      cyc_q      <= 32'h0;
      ovf_q      <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_word_q  <= rd_word_d;
      rd_off_q   <= rd_off_d;
      rd_size_q  <= rd_size_d;
      rd_uns_q   <= rd_uns_d;
      err_q      <= err_d;
      eaddr_q    <= eaddr_d;
      cyc_q      <= cyc_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign misalign_err = err_q;
  assign err_addr     = eaddr_q;

endmodule
